// File: rtl/popcount_pkg.sv
// Shared types and sizing helpers for the binarized popcount accumulation path.
package popcount_pkg;

  typedef enum logic {
    ACC,
    OUT
  } state_e;

  localparam int unsigned COUNT_WIDTH = 4;
  localparam int unsigned ACC_WIDTH   = 12;

  // Largest unsigned value representable in 'width' bits (capped at 32 bits).
  function automatic logic [31:0] sat_max(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/popcount_accum_sat_add.sv
// Unsigned saturating add of a popcount chunk onto the running accumulator.
module sat_add
  import popcount_pkg::*;
#(
  parameter int unsigned AccWidth   = ACC_WIDTH,
  parameter int unsigned CountWidth = COUNT_WIDTH
) (
  input  logic [AccWidth-1:0]   acc,
  input  logic [CountWidth-1:0] count,
  output logic [AccWidth-1:0]   sum,
  output logic                  clamped
);

  localparam int unsigned WideWidth = AccWidth + 1;
  localparam logic [AccWidth-1:0] MaxVal = AccWidth'(sat_max(AccWidth));

  logic [WideWidth-1:0] wide;

  // One extra bit catches the carry out; any carry means the clamp engages.
  always_comb begin
    wide    = WideWidth'(acc) + WideWidth'(count);
    clamped = wide[AccWidth];
    sum     = clamped ? MaxVal : wide[AccWidth-1:0];
  end

endmodule

// File: rtl/popcount_accum.sv
// Accumulates per-chunk popcounts over a last-delimited vector and emits the
// thresholded activation bit with the raw saturated sum.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int unsigned CountWidth = COUNT_WIDTH,
  parameter int unsigned AccWidth   = ACC_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in_valid,
  output logic                  io_in_ready,
  input  logic [CountWidth-1:0] io_in_count,
  input  logic                  io_in_last,
  input  logic [AccWidth-1:0]   io_thresh,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic                  io_out_bit,
  output logic [AccWidth-1:0]   io_out_sum,
  output logic                  io_out_sat
);

  state_e              state;
  logic [AccWidth-1:0] acc;
  logic [AccWidth-1:0] thresh_q;
  logic                sat_flag;
  logic                mid_vec;

  logic [AccWidth-1:0] add_sum;
  logic                add_clamp;
  logic [AccWidth-1:0] thresh_cur;
  logic                beat;
  logic                take;
  logic                sat_next;

  sat_add #(
    .AccWidth  (AccWidth),
    .CountWidth(CountWidth)
  ) u_sat_add (
    .acc    (acc),
    .count  (io_in_count),
    .sum    (add_sum),
    .clamped(add_clamp)
  );

  assign io_in_ready  = (state == ACC) || io_out_ready;
  assign io_out_valid = (state == OUT);

  assign beat     = io_in_valid && io_in_ready;
  assign take     = io_out_valid && io_out_ready;
  assign sat_next = sat_flag || add_clamp;
  // The first beat of a vector compares against the live threshold so a
  // single-beat vector sees the value being captured on that same edge.
  assign thresh_cur = mid_vec ? thresh_q : io_thresh;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ACC;
      acc        <= '0;
      thresh_q   <= '0;
      sat_flag   <= 1'b0;
      mid_vec    <= 1'b0;
      io_out_bit <= 1'b0;
      io_out_sum <= '0;
      io_out_sat <= 1'b0;
    end else begin
      if (take) begin
        state <= ACC;
      end
      if (beat) begin
        if (!mid_vec) begin
          thresh_q <= io_thresh;
        end
        if (io_in_last) begin
          io_out_sum <= add_sum;
          io_out_bit <= (add_sum >= thresh_cur);
          io_out_sat <= sat_next;
          acc        <= '0;
          sat_flag   <= 1'b0;
          mid_vec    <= 1'b0;
          state      <= OUT;
        end else begin
          acc      <= add_sum;
          sat_flag <= sat_next;
          mid_vec  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Scoreboard bench for popcount_accum: a 12-bit instance for the main tests
// and a 5-bit instance for saturation.
module tb_popcount_accum;

  localparam int unsigned CW  = 4;
  localparam int unsigned AW  = 12;
  localparam int unsigned AWS = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          valid_a, valid_b, io_in_last, io_out_ready;
  logic [CW-1:0] io_in_count;
  logic [AW-1:0] io_thresh;

  logic           ready_a, ready_b, ov_a, ov_b, bit_a, bit_b, sat_a, sat_b;
  logic [AW-1:0]  sum_a;
  logic [AWS-1:0] sum_b;

  popcount_accum #(.CountWidth(CW), .AccWidth(AW)) dut_a (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (valid_a),
    .io_in_ready (ready_a),
    .io_in_count (io_in_count),
    .io_in_last  (io_in_last),
    .io_thresh   (io_thresh),
    .io_out_valid(ov_a),
    .io_out_ready(io_out_ready),
    .io_out_bit  (bit_a),
    .io_out_sum  (sum_a),
    .io_out_sat  (sat_a)
  );

  popcount_accum #(.CountWidth(CW), .AccWidth(AWS)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (valid_b),
    .io_in_ready (ready_b),
    .io_in_count (io_in_count),
    .io_in_last  (io_in_last),
    .io_thresh   (io_thresh[AWS-1:0]),
    .io_out_valid(ov_b),
    .io_out_ready(io_out_ready),
    .io_out_bit  (bit_b),
    .io_out_sum  (sum_b),
    .io_out_sat  (sat_b)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        act;
    logic        sat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int m_sum[2];
  int m_thr[2];
  bit m_first[2];
  bit m_sat[2];

  task automatic model_clear(input int s);
    m_sum[s]   = 0;
    m_sat[s]   = 1'b0;
    m_first[s] = 1'b1;
  endtask

  // Presents one beat and holds it until accepted; returns cycles spent waiting.
  task automatic send_beat(input int s, input int cnt, input bit last, output int waits);
    int mx;
    bit ok;
    exp_t e;
    mx = (s == 1) ? 31 : 4095;
    ok = 1'b0;
    waits = 0;
    io_in_count = CW'(cnt);
    io_in_last  = last;
    valid_a     = (s == 0);
    valid_b     = (s == 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if ((s == 0) ? ready_a : ready_b) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) begin
      check("beat_timeout", 32'd0, 32'd1);
      valid_a = 1'b0;
      valid_b = 1'b0;
      return;
    end
    if (m_first[s]) m_thr[s] = int'(io_thresh) & mx;
    m_first[s] = 1'b0;
    m_sum[s] = m_sum[s] + cnt;
    if (m_sum[s] > mx) begin
      m_sum[s] = mx;
      m_sat[s] = 1'b1;
    end
    if (last) begin
      e.sum = 32'(m_sum[s]);
      e.act = (m_sum[s] >= m_thr[s]);
      e.sat = m_sat[s];
      if (s == 0) q_a.push_back(e);
      else q_b.push_back(e);
      model_clear(s);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Results are compared on the cycle they are taken.
  always @(negedge clock) begin
    exp_t e;
    if (reset && ov_a && io_out_ready) begin
      if (q_a.size() == 0) check("unexpected_a", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        check("sum_a", 32'(sum_a), e.sum);
        check("bit_a", 32'(bit_a), 32'(e.act));
        check("sat_a", 32'(sat_a), 32'(e.sat));
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset && ov_b && io_out_ready) begin
      if (q_b.size() == 0) check("unexpected_b", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        check("sum_b", 32'(sum_b), e.sum);
        check("bit_b", 32'(bit_b), 32'(e.act));
        check("sat_b", 32'(sat_b), 32'(e.sat));
      end
    end
  end

  initial begin
    int w;
    model_clear(0);
    model_clear(1);
    valid_a      = 1'b0;
    valid_b      = 1'b0;
    io_in_last   = 1'b0;
    io_in_count  = '0;
    io_thresh    = '0;
    io_out_ready = 1'b1;

    #1;
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_valid", 32'(ov_a), 32'd0);
    check("rst_sum", 32'(sum_a), 32'd0);
    check("rst_bit", 32'(bit_a), 32'd0);
    check("rst_sat", 32'(sat_a), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single vector, then threshold boundary cases.
    io_thresh = 12'd10;
    send_beat(0, 3, 0, w);
    send_beat(0, 4, 0, w);
    send_beat(0, 5, 1, w);
    check("latency_valid", 32'(ov_a), 32'd1);
    io_thresh = 12'd12;
    send_beat(0, 3, 0, w);
    send_beat(0, 4, 0, w);
    send_beat(0, 5, 1, w);
    io_thresh = 12'd13;
    send_beat(0, 3, 0, w);
    io_thresh = 12'd0;
    send_beat(0, 4, 0, w);
    send_beat(0, 5, 1, w);
    idle(2);

    // Back-to-back vectors with no bubble.
    io_thresh = 12'd10;
    send_beat(0, 8, 0, w);
    check("b2b_wait0", 32'(w), 32'd0);
    send_beat(0, 8, 1, w);
    check("b2b_wait1", 32'(w), 32'd0);
    send_beat(0, 1, 1, w);
    check("b2b_wait2", 32'(w), 32'd0);
    idle(2);

    // Backpressure: result held while downstream stalls.
    io_out_ready = 1'b0;
    send_beat(0, 3, 0, w);
    send_beat(0, 4, 0, w);
    send_beat(0, 5, 1, w);
    valid_a     = 1'b1;
    io_in_count = CW'(2);
    io_in_last  = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("bp_ready", 32'(ready_a), 32'd0);
      check("bp_valid", 32'(ov_a), 32'd1);
      check("bp_sum", 32'(sum_a), 32'd12);
      check("bp_bit", 32'(bit_a), 32'd1);
    end
    @(posedge clock);
    #1;
    io_out_ready = 1'b1;
    send_beat(0, 2, 1, w);
    check("bp_release_wait", 32'(w), 32'd0);
    idle(2);

    // Saturation on the 5-bit instance, then a clean vector.
    io_thresh = 12'd20;
    repeat (4) send_beat(1, 8, 0, w);
    send_beat(1, 8, 1, w);
    send_beat(1, 2, 1, w);
    idle(2);

    // Reset mid-vector discards partial state.
    io_thresh = 12'd5;
    send_beat(0, 7, 0, w);
    send_beat(0, 7, 0, w);
    valid_a = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_clear(0);
    check("mid_rst_ready", 32'(ready_a), 32'd1);
    check("mid_rst_valid", 32'(ov_a), 32'd0);
    check("mid_rst_sum", 32'(sum_a), 32'd0);
    check("mid_rst_bit", 32'(bit_a), 32'd0);
    check("mid_rst_sat", 32'(sat_a), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    send_beat(0, 1, 1, w);
    idle(3);

    check("pending_a", 32'(q_a.size()), 32'd0);
    check("pending_b", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
